// File: rtl/bus_fifo_flow.sv
// Single-clock show-ahead bus FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module bus_fifo_flow #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned ADDR_BITS    = 3,
   parameter int unsigned AFULL_LEVEL  = 6,
   parameter int unsigned AEMPTY_LEVEL = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 data_strobe_i,
   input  logic [WIDTH-1:0]     data_in_i,
   output logic                 data_ready_o,
   output logic [WIDTH-1:0]     data_out_o,
   input  logic                 data_ack_i,
   output logic                 full_o,
   output logic                 almost_full_o,
   output logic                 almost_empty_o,
   output logic [ADDR_BITS:0]   count_o,
   output logic                 overflow_o,
   output logic                 underflow_o,
   input  logic                 clear_err_i
);

   localparam int unsigned DEPTH = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS:0] AFULL_CNT  = AFULL_LEVEL[ADDR_BITS:0];
   localparam logic [ADDR_BITS:0] AEMPTY_CNT = AEMPTY_LEVEL[ADDR_BITS:0];

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [ADDR_BITS:0] wrPtr_q, wrPtr_d;
   logic [ADDR_BITS:0] rdPtr_q, rdPtr_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;

   logic isEmpty;
   logic isFull;
   logic pushOk;
   logic popOk;

   // The extra pointer MSB tells a full ring apart from an empty one.
   assign isEmpty = (wrPtr_q == rdPtr_q);
   assign isFull  = (wrPtr_q[ADDR_BITS-1:0] == rdPtr_q[ADDR_BITS-1:0]) &&
                    (wrPtr_q[ADDR_BITS] != rdPtr_q[ADDR_BITS]);
   assign pushOk  = data_strobe_i & ~isFull;
   assign popOk   = data_ack_i & ~isEmpty;

   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
      end else begin
         if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
         if (popOk)  rdPtr_d = rdPtr_q + 1'b1;
      end
      // A clear in the same cycle as a new error loses to the error.
      if (clear_err_i) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (data_strobe_i && isFull) overflow_d  = 1'b1;
      if (data_ack_i && isEmpty)   underflow_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (pushOk && !flush_i) mem_q[wrPtr_q[ADDR_BITS-1:0]] <= data_in_i;
   end

   assign count_o        = wrPtr_q - rdPtr_q;
   assign data_ready_o   = ~isEmpty;
   assign data_out_o     = isEmpty ? '0 : mem_q[rdPtr_q[ADDR_BITS-1:0]];
   assign full_o         = isFull;
   assign almost_full_o  = (count_o >= AFULL_CNT);
   assign almost_empty_o = (count_o <= AEMPTY_CNT);
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_bus_fifo_flow.sv
// Bench for bus_fifo_flow: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_bus_fifo_flow;

   localparam int DEPTH = 8;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       strobe;
   logic [7:0] din;
   logic       ready;
   logic [7:0] dout;
   logic       ack;
   logic       full;
   logic       aFull;
   logic       aEmpty;
   logic [3:0] count;
   logic       ovf;
   logic       unf;
   logic       clr;

   int total = 0;
   int bad   = 0;

   byte unsigned modelQ[$];
   bit           modelOvf;
   bit           modelUnf;

   typedef struct {
      logic       strobe;
      logic       ack;
      logic       clr;
      logic [7:0] din;
      int         expCount;
      logic [7:0] expDout;
      logic       expOvf;
      logic       expUnf;
   } vec_t;

   vec_t vecs[$];

   bus_fifo_flow #(
      .WIDTH(8), .ADDR_BITS(3), .AFULL_LEVEL(6), .AEMPTY_LEVEL(1)
   ) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .data_strobe_i(strobe), .data_in_i(din),
      .data_ready_o(ready), .data_out_o(dout), .data_ack_i(ack),
      .full_o(full), .almost_full_o(aFull), .almost_empty_o(aEmpty),
      .count_o(count), .overflow_o(ovf), .underflow_o(unf),
      .clear_err_i(clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output word derived purely from an occupancy and head value.
   function automatic logic [31:0] expPack(int cnt, logic [7:0] head, logic o, logic u);
      return {14'b0, 4'(cnt), (cnt > 0), (cnt == DEPTH), (cnt >= 6), (cnt <= 1), o, u, head};
   endfunction

   function automatic logic [31:0] dutPack();
      return {14'b0, count, ready, full, aFull, aEmpty, ovf, unf, dout};
   endfunction

   function automatic logic [31:0] modelPack();
      return expPack(modelQ.size(), (modelQ.size() > 0) ? modelQ[0] : 8'h00, modelOvf, modelUnf);
   endfunction

   task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   task automatic modelStep(logic s, logic a, logic f, logic c, logic [7:0] d);
      bit wasFull;
      bit wasEmpty;
      wasFull  = (modelQ.size() == DEPTH);
      wasEmpty = (modelQ.size() == 0);
      if (c) begin
         modelOvf = 1'b0;
         modelUnf = 1'b0;
      end
      if (s && wasFull)  modelOvf = 1'b1;
      if (a && wasEmpty) modelUnf = 1'b1;
      if (f) begin
         modelQ.delete();
      end else begin
         if (a && !wasEmpty) void'(modelQ.pop_front());
         if (s && !wasFull)  modelQ.push_back(d);
      end
   endtask

   task automatic applyStimulus(logic s, logic a, logic f, logic c, logic [7:0] d);
      strobe = s;
      ack    = a;
      flush  = f;
      clr    = c;
      din    = d;
      @(posedge clk);
      modelStep(s, a, f, c, d);
      #1;
      strobe = 1'b0;
      ack    = 1'b0;
      flush  = 1'b0;
      clr    = 1'b0;
      din    = 8'h00;
   endtask

   task automatic checkOutput(string name);
      compare(name, dutPack(), modelPack());
   endtask

   initial begin
      vec_t v;
      int   cnt;

      rst = 1'b1; flush = 1'b0; strobe = 1'b0; ack = 1'b0; clr = 1'b0; din = 8'h00;
      modelQ.delete(); modelOvf = 1'b0; modelUnf = 1'b0;

      // Fill, overfill, drain, then the underflow/clear corner.
      for (int i = 0; i < 8; i++) begin
         v = '{1'b1, 1'b0, 1'b0, 8'(i + 1), i + 1, 8'h01, 1'b0, 1'b0};
         vecs.push_back(v);
      end
      vecs.push_back('{1'b1, 1'b0, 1'b0, 8'hFF, 8, 8'h01, 1'b1, 1'b0});
      for (int k = 0; k < 8; k++) begin
         cnt = 7 - k;
         v = '{1'b0, 1'b1, 1'b0, 8'h00, cnt, (cnt > 0) ? 8'(k + 2) : 8'h00, 1'b1, 1'b0};
         vecs.push_back(v);
      end
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h5A, 1, 8'h5A, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h5A, 1'b0, 1'b0});

      #1;
      compare("reset_async", dutPack(), expPack(0, 8'h00, 1'b0, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      compare("reset_idle", dutPack(), expPack(0, 8'h00, 1'b0, 1'b0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].strobe, vecs[i].ack, 1'b0, vecs[i].clr, vecs[i].din);
         compare($sformatf("vec%0d", i), dutPack(),
                 expPack(vecs[i].expCount, vecs[i].expDout, vecs[i].expOvf, vecs[i].expUnf));
         checkOutput($sformatf("vec%0d_model", i));
      end

      // Bring occupancy to 3, then stream through pointer rollover.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
      checkOutput("wrap_fill");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
         checkOutput($sformatf("wrap%0d", i));
         compare($sformatf("wrap%0d_count", i), 32'(count), 32'd3);
      end

      while (modelQ.size() < DEPTH) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
      checkOutput("full_reached");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
      checkOutput("full_push_pop");
      compare("full_push_pop_cnt", {count, 3'b0, ovf}, {4'd7, 3'b0, 1'b1});

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("pre_flush");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
      checkOutput("flush");
      compare("flush_direct", {count, dout}, 12'h000);

      // Reset pulse in the middle of a push burst, checked before the next edge.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hA1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hA2);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hA3);
      checkOutput("pre_reset");
      strobe = 1'b1;
      din    = 8'hA4;
      #2;
      rst = 1'b1;
      #1;
      compare("reset_midburst", dutPack(), expPack(0, 8'h00, 1'b0, 1'b0));
      modelQ.delete(); modelOvf = 1'b0; modelUnf = 1'b0;
      @(posedge clk);
      #1;
      compare("reset_held", dutPack(), expPack(0, 8'h00, 1'b0, 1'b0));
      rst    = 1'b0;
      strobe = 1'b0;

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(99) < 55), ($urandom_range(99) < 50),
                       ($urandom_range(99) < 3), ($urandom_range(99) < 5), 8'($urandom));
         checkOutput($sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
